// File: rtl/flexka_pkg.sv
// flexka_pkg: shared FLEXKA sizing constants and the stack-node status type.
package flexka_pkg;
    localparam int SSIZE             = 8;
    localparam int STACK_BUFFER_SIZE = 8;
    localparam int SDEPTH_W          = $clog2(STACK_BUFFER_SIZE + 1);

    typedef struct packed {
        logic [SDEPTH_W-1:0] depth;
        logic                empty;
        logic                full;
        logic                overflow_err;
        logic                underflow_err;
    } stack_status_t;
endpackage

// File: rtl/flexka_stack_ram.sv
// flexka_stack_ram: simple dual-port storage with a registered read port.
module flexka_stack_ram #(
    parameter int W = 16,
    parameter int N = 8,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [N];

    // a read and write to the same address in one cycle returns the old word
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/flexka_stack_multi_node.sv
// flexka_stack_multi_node: LIFO of NFIELDS-wide entries with one-cycle pop result,
// same-cycle push/pop replace, empty pass-through and sticky error flags.
module flexka_stack_multi_node
    import flexka_pkg::*;
#(
    parameter int NFIELDS = 2,
    parameter int FIELD_W = SSIZE,
    parameter int DEPTH   = STACK_BUFFER_SIZE
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [NFIELDS*FIELD_W-1:0]   in_fields,
    output logic [NFIELDS*FIELD_W-1:0]   pop_fields,
    output logic                         pop_valid,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow_err,
    output logic                         underflow_err
);
    localparam int W  = NFIELDS * FIELD_W;
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    // src selects the RAM read register (1) or the local hold register (0) as pop_fields
    typedef struct packed {
        logic [DW-1:0] depth;
        logic          ovf;
        logic          unf;
        logic          pop_valid;
        logic          src;
        logic [W-1:0]  hold;
    } state_t;

    state_t        r, nx;
    logic          live, is_empty, is_full, both, do_pop, do_push, we, re;
    logic [AW-1:0] top, waddr;
    logic [W-1:0]  ram_q;

    assign is_empty = r.depth == '0;
    assign is_full  = r.depth == DW'(DEPTH);
    assign live     = rstn && !clear;
    assign both     = push && pop;
    assign do_pop   = pop && !is_empty;
    assign do_push  = push && !pop && !is_full;
    assign top      = AW'(r.depth - DW'(1));
    assign waddr    = do_push ? AW'(r.depth) : top;
    assign we       = live && (do_push || (both && !is_empty));
    assign re       = live && do_pop;

    always_comb begin
        nx = r;
        nx.pop_valid = 1'b0;
        if (!rstn) begin
            nx = '0;
        end else if (clear) begin
            nx.depth = '0;
            nx.ovf   = 1'b0;
            nx.unf   = 1'b0;
        end else begin
            if (both && is_empty) begin
                nx.hold      = in_fields;
                nx.src       = 1'b0;
                nx.pop_valid = 1'b1;
            end
            if (do_pop) begin
                nx.src       = 1'b1;
                nx.pop_valid = 1'b1;
            end
            if (do_push) nx.depth = r.depth + DW'(1);
            if (pop && !push && !is_empty) nx.depth = r.depth - DW'(1);
            if (push && !pop && is_full) nx.ovf = 1'b1;
            if (pop && !push && is_empty) nx.unf = 1'b1;
        end
    end

    always_ff @(posedge clk) r <= nx;

    flexka_stack_ram #(.W(W), .N(DEPTH)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (in_fields),
        .re    (re),
        .raddr (top),
        .rdata (ram_q)
    );

    assign pop_fields    = r.src ? ram_q : r.hold;
    assign pop_valid     = r.pop_valid;
    assign depth         = r.depth;
    assign empty         = is_empty;
    assign full          = is_full;
    assign overflow_err  = r.ovf;
    assign underflow_err = r.unf;
endmodule

// File: doc/flexka_stack_multi_node.md
FLEXKA_STACK_MULTI_NODE -- requirements
Module: flexka_stack_multi_node

Interface
REQ-001 SHALL have parameter NFIELDS, default 2: number of fields per stack entry.
REQ-002 SHALL have parameter FIELD_W, default SSIZE: width of each field in bits.
REQ-003 SHALL have parameter DEPTH, default STACK_BUFFER_SIZE: entry capacity, with DEPTH >= 2.
REQ-004 SHALL have port clk, input, 1: clock, all logic on the rising edge.
REQ-005 SHALL have port rstn, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port clear, input, 1: synchronous flush of the stack contents and error flags.
REQ-007 SHALL have port push, input, 1: write in_fields as the new top entry.
REQ-008 SHALL have port pop, input, 1: remove the top entry and return it on pop_fields.
REQ-009 SHALL have port in_fields, input, NFIELDS x FIELD_W: push data.
REQ-010 SHALL have port pop_fields, output, NFIELDS x FIELD_W: registered pop result.
REQ-011 SHALL have port pop_valid, output, 1: one-cycle pulse marking a new pop_fields value.
REQ-012 SHALL have port depth, output, $clog2(DEPTH+1): current entry count.
REQ-013 SHALL have ports empty and full, output, 1 each: empty is (depth==0); full is (depth==DEPTH).
REQ-014 SHALL have ports overflow_err and underflow_err, output, 1 each: sticky error flags.

Function
REQ-015 Push only, not full: SHALL write in_fields at address depth and increment depth at the next edge.
REQ-016 Pop only, not empty: SHALL load the entry at address depth-1 into pop_fields, assert pop_valid, and decrement depth, all at the next edge.
REQ-017 Pop latency: pop_fields/pop_valid SHALL update exactly one cycle after the pop cycle.
REQ-018 pop_fields SHALL hold its value until the next valid pop and SHALL NOT change on a push.
REQ-019 Push and pop together, not empty: pop_fields SHALL receive the old top, in_fields SHALL overwrite address depth-1, and depth SHALL be unchanged. This holds when full.
REQ-020 Push and pop together, empty: pop_fields SHALL receive in_fields (pass-through), pop_valid SHALL assert, depth SHALL stay 0 and underflow_err SHALL stay unchanged.
REQ-021 Push while full without pop: SHALL be ignored (no write, depth unchanged) and SHALL set overflow_err.
REQ-022 Pop while empty without push: SHALL be ignored, with no pop_valid and pop_fields unchanged, and SHALL set underflow_err.
REQ-023 Back-to-back operations (push then pop on the next cycle, or pop then pop) SHALL return correct data every cycle with no stall. Where the memory read path is one cycle late, a write-bypass register SHALL supply the data.
REQ-024 clear SHALL force depth to 0 and clear both error flags at the next edge, and SHALL deassert pop_valid. pop_fields SHALL be retained.
REQ-025 clear SHALL take priority over push and pop issued in the same cycle.
REQ-026 Error flags SHALL remain set until clear or reset.
REQ-027 Depth arithmetic SHALL never wrap. Illegal operations are suppressed per REQ-021 and REQ-022.

Reset
REQ-028 While rstn==0 at a clock edge, the block SHALL set depth=0, pop_valid=0, pop_fields=0, overflow_err=0 and underflow_err=0.
REQ-029 Reset SHALL override clear, push and pop.
REQ-030 Memory contents are undefined after reset and SHALL NOT be readable as valid data.
REQ-031 Reset asserted mid-operation SHALL abort the operation, so a pop in the reset cycle produces no pop_valid.

Structure
REQ-032 SSIZE and STACK_BUFFER_SIZE SHALL come from FLEXKA_PKG. FLEXKA_PKG SHALL also hold a new typedef for stack-node status (depth, empty, full, errors).
REQ-033 Storage SHALL be one sub-module, flexka_stack_ram: simple dual-port, NFIELDS*FIELD_W wide, DEPTH deep, 1-cycle registered read.
REQ-034 All state SHALL be held in one register struct, with a single combinational next-state block.

Verification
REQ-035 Reset, then push 0x11/0x22, 0x33/0x44, 0x55/0x66, then 3 pops -> pop_fields 0x55/0x66, 0x33/0x44, 0x11/0x22 on consecutive cycles; depth ends at 0 and empty=1.
REQ-036 Fill to DEPTH, then one more push -> full=1, overflow_err=1, depth=DEPTH; the next pop returns the last legal entry.
REQ-037 Empty stack, pop -> underflow_err=1 and no pop_valid. Then push+pop of 0x7/0x9 together -> pop_fields=0x7/0x9, pop_valid=1, depth=0.
REQ-038 Depth 2 holding A then B; push C with pop in the same cycle -> pop_fields=B, depth=2. The next two pops return C, then A.
REQ-039 Push on cycle N and pop on cycle N+1 -> pop_fields equals the pushed data at N+2 (bypass path).
REQ-040 Assert clear with errors set and depth=5, together with a push -> depth=0 and both flags 0. Assert rstn=0 during a pop -> no pop_valid and all outputs at reset values.
